and_delay_checker: RTL and testbench

//   Clocked response checker for the two-input AND stage that drives its output through a delayed net.

---
 rtl/and_delay_checker_if.sv | 24 ++
 rtl/and_delay_checker.sv | 116 +++++++++++
 tb/tb_and_delay_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/and_delay_checker_if.sv
// Stimulus/response bundle between the AND-stage driver and its delay checker.
interface and_delay_checker_if #(
    parameter int CNT_W = 16
) ();
    logic             enable;
    logic             in1;
    logic             in2;
    logic             out_obs;
    logic             exp_out;
    logic             valid;
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             err_flag;

    modport master (
        output enable, in1, in2, out_obs,
        input  exp_out, valid, mismatch, mismatch_cnt, err_flag
    );

    modport slave (
        input  enable, in1, in2, out_obs,
        output exp_out, valid, mismatch, mismatch_cnt, err_flag
    );
endinterface

// File: rtl/and_delay_checker.sv
// Inertial-delay response checker for a two-input AND stage driving a delayed net.
// Optional DLY_CHECK_STICKY_EN: err_flag latches the first mismatch until reset.
module and_delay_checker #(
    parameter int DELAY = 10,
    parameter int DLY_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    and_delay_checker_if.slave    bus
);
    typedef enum logic [1:0] {WARM, IDLE, PEND} state_t;

    localparam logic [DLY_W-1:0] LAST    = DLY_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [DLY_W-1:0] dly_cnt;
    logic             in1_q, in2_q, obs_q, en_q;
    logic             tgt_prev;
    logic             exp_q, valid_q, mis_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tgt, hit;

    // Everything downstream works on the registered copies only.
    assign tgt = in1_q & in2_q;
    assign hit = valid_q & en_q & (obs_q != exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WARM;
            dly_cnt  <= '0;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            obs_q    <= 1'b0;
            en_q     <= 1'b0;
            tgt_prev <= 1'b0;
            exp_q    <= 1'b0;
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            in1_q    <= bus.in1;
            in2_q    <= bus.in2;
            obs_q    <= bus.out_obs;
            en_q     <= bus.enable;
            tgt_prev <= tgt;
            mis_q    <= hit;
            if (hit && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;

            case (state)
                WARM: begin
                    if (tgt != tgt_prev) begin
                        dly_cnt <= '0;
                    end else if (dly_cnt == LAST) begin
                        exp_q   <= tgt;
                        valid_q <= 1'b1;
                        dly_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (tgt != exp_q) begin
                        // A one-cycle delay is a plain registered follow.
                        if (DELAY == 1) begin
                            exp_q <= tgt;
                        end else begin
                            state   <= PEND;
                            dly_cnt <= DLY_W'(1);
                        end
                    end
                end
                PEND: begin
                    if (tgt == exp_q) begin
                        state   <= IDLE;
                        dly_cnt <= '0;
                    end else if (dly_cnt == LAST) begin
                        exp_q   <= tgt;
                        state   <= IDLE;
                        dly_cnt <= '0;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= WARM;
                    dly_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.exp_out      = exp_q;
    assign bus.valid        = valid_q;
    assign bus.mismatch     = mis_q;
    assign bus.mismatch_cnt = cnt_q;

`ifdef DLY_CHECK_STICKY_EN
    logic err_q;

    // Set in the same cycle the mismatch pulse appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (hit)
            err_q <= 1'b1;
    end

    assign bus.err_flag = err_q;
`else
    assign bus.err_flag = mis_q;
`endif
endmodule

// File: tb/tb_and_delay_checker.sv
// Directed bench for and_delay_checker: a window-based inertial model runs alongside two instances.
module tb_and_delay_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in1 = 1'b0, in2 = 1'b0, enable = 1'b1, out_obs = 1'b0, out_obs2 = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    and_delay_checker_if #(.CNT_W(16)) bus0 ();
    and_delay_checker_if #(.CNT_W(3))  bus1 ();

    assign bus0.in1 = in1;  assign bus0.in2 = in2;
    assign bus0.enable = enable;  assign bus0.out_obs = out_obs;
    assign bus1.in1 = in1;  assign bus1.in2 = in2;
    assign bus1.enable = enable;  assign bus1.out_obs = out_obs2;

    and_delay_checker #(.DELAY(10), .DLY_W(8), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    and_delay_checker #(.DELAY(1),  .DLY_W(8), .CNT_W(3))  u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Model: exp_out takes value v once the last DELAY samples all equal v;
    // warm-up needs DELAY+1 equal samples (pre-reset history reads as 0) and DELAY edges.
    typedef struct packed {
        logic [31:0] hist;
        int          n;
        logic        valid;
        logic        exp;
        logic        mis;
        logic        err;
        int          cnt;
    } mstate_t;

    function automatic logic all_eq(logic [31:0] h, int k);
        logic [31:0] m;
        m = (32'd1 << k) - 32'd1;
        return ((h & m) == 32'd0) || ((h & m) == m);
    endfunction

    function automatic mstate_t mstep(mstate_t s, int d, int cmax, logic seen, logic obs, logic en);
        mstate_t r;
        logic    mis;
        r      = s;
        r.hist = {s.hist[30:0], seen};
        if (s.n < 1000) r.n = s.n + 1;
        mis   = s.valid & en & (obs != s.exp);
        r.mis = mis;
        if (mis && s.cnt < cmax) r.cnt = s.cnt + 1;
`ifdef DLY_CHECK_STICKY_EN
        r.err = s.err | mis;
`else
        r.err = mis;
`endif
        if (!s.valid) begin
            if (r.n >= d && all_eq(r.hist, d + 1)) begin
                r.valid = 1'b1;
                r.exp   = seen;
            end
        end else if (all_eq(r.hist, d) && seen != s.exp) begin
            r.exp = seen;
        end
        return r;
    endfunction

    mstate_t ms [2];
    logic    p_tgt, p_obs0, p_obs1, p_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms[0] <= '0;  ms[1] <= '0;
            p_tgt <= 1'b0;  p_obs0 <= 1'b0;  p_obs1 <= 1'b0;  p_en <= 1'b0;
        end else begin
            ms[0]  <= mstep(ms[0], 10, 65535, p_tgt, p_obs0, p_en);
            ms[1]  <= mstep(ms[1], 1, 7, p_tgt, p_obs1, p_en);
            p_tgt  <= in1 & in2;
            p_obs0 <= out_obs;
            p_obs1 <= out_obs2;
            p_en   <= enable;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("d10 valid", int'(bus0.valid), int'(ms[0].valid));
        chk("d10 exp_out", int'(bus0.exp_out), int'(ms[0].exp));
        chk("d10 mismatch", int'(bus0.mismatch), int'(ms[0].mis));
        chk("d10 mismatch_cnt", int'(bus0.mismatch_cnt), ms[0].cnt);
        chk("d10 err_flag", int'(bus0.err_flag), int'(ms[0].err));
        chk("d1 valid", int'(bus1.valid), int'(ms[1].valid));
        chk("d1 exp_out", int'(bus1.exp_out), int'(ms[1].exp));
        chk("d1 mismatch", int'(bus1.mismatch), int'(ms[1].mis));
        chk("d1 mismatch_cnt", int'(bus1.mismatch_cnt), ms[1].cnt);
        chk("d1 err_flag", int'(bus1.err_flag), int'(ms[1].err));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;

        // warm-up with quiet inputs
        step(12);
        chk("warm valid", int'(bus0.valid), 1);
        chk("warm exp_out", int'(bus0.exp_out), 0);
        chk("warm cnt", int'(bus0.mismatch_cnt), 0);

        // clean rising and falling edge, out_obs follows 10 cycles later
        in1 = 1'b1;  in2 = 1'b1;
        step(10);
        chk("edge exp before", int'(bus0.exp_out), 0);
        out_obs = 1'b1;
        step(1);
        chk("edge exp after", int'(bus0.exp_out), 1);
        step(3);
        in1 = 1'b0;
        step(10);
        out_obs = 1'b0;
        step(3);
        chk("edge cnt", int'(bus0.mismatch_cnt), 0);
        chk("sat cnt", int'(bus1.mismatch_cnt), 7);

        // 5-cycle glitch swallowed
        in1 = 1'b1;
        step(5);
        in1 = 1'b0;
        step(15);
        chk("glitch exp", int'(bus0.exp_out), 0);
        chk("glitch cnt", int'(bus0.mismatch_cnt), 0);

        // glitch echoed on out_obs: five mismatches
        in1 = 1'b1;  out_obs = 1'b1;
        step(5);
        in1 = 1'b0;  out_obs = 1'b0;
        step(5);
        chk("echo cnt", int'(bus0.mismatch_cnt), 5);
        chk("sat hold", int'(bus1.mismatch_cnt), 7);
        step(10);
`ifdef DLY_CHECK_STICKY_EN
        chk("err sticky", int'(bus0.err_flag), 1);
`else
        chk("err pulse gone", int'(bus0.err_flag), 0);
`endif

        // mismatch hidden by enable=0
        enable = 1'b0;
        step(1);
        out_obs = 1'b1;
        step(4);
        out_obs = 1'b0;
        step(2);
        enable = 1'b1;
        step(3);
        chk("disabled cnt", int'(bus0.mismatch_cnt), 5);

        // async reset while pending
        in1 = 1'b1;
        step(7);
        #1 rst_n = 1'b0;
        #1;
        chk("rst valid", int'(bus0.valid), 0);
        chk("rst exp_out", int'(bus0.exp_out), 0);
        chk("rst mismatch", int'(bus0.mismatch), 0);
        chk("rst cnt", int'(bus0.mismatch_cnt), 0);
        chk("rst err", int'(bus0.err_flag), 0);
        chk("rst sat cnt", int'(bus1.mismatch_cnt), 0);
        in1 = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(9);
        chk("rewarm early", int'(bus0.valid), 0);
        step(1);
        chk("rewarm done", int'(bus0.valid), 1);

        // 9-cycle pulse swallowed, 10-cycle pulse passes
        in1 = 1'b1;
        step(9);
        in1 = 1'b0;
        step(12);
        chk("pulse9 exp", int'(bus0.exp_out), 0);
        in1 = 1'b1;
        step(10);
        in1 = 1'b0;  out_obs = 1'b1;
        step(1);
        chk("pulse10 exp", int'(bus0.exp_out), 1);
        step(9);
        out_obs = 1'b0;
        step(12);
        chk("pulse10 done", int'(bus0.exp_out), 0);
        chk("pulse cnt", int'(bus0.mismatch_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
